riscv_icache_lite: RTL and testbench
====================================

Name: riscv_icache_lite

Overview:
Small direct-mapped, blocking instruction cache. It is the responder on the icache_* request/response interface driven by the fetch stage.
- Accepts one fetch request at a time.
- Hits return one cycle after acceptance.
- Misses refill a 4-word line from a simple single-outstanding memory port.
- Sits between riscv_fetch and the core's instruction memory/bus bridge; no MMU, so page faults are never raised.

Parameters:
NUM_LINES, 64, number of cache lines; power of two, minimum 2. IDX_W = $clog2(NUM_LINES).
LINE_WORDS, 4, words per line; fixed at 4 (offset = pc[3:2]); parameter exists for the package constant only.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
icache_rd_i  in  1  fetch request valid
icache_pc_i  in  32  fetch address; bits [1:0] ignored
icache_priv_i  in  2  privilege; unused (no MMU), kept for interface compatibility
icache_flush_i  in  1  pulse: invalidate all lines
icache_invalidate_i  in  1  pulse: treated identically to flush
icache_accept_o  out  1  request accepted this cycle when icache_rd_i & icache_accept_o
icache_valid_o  out  1  single-cycle response strobe
icache_inst_o  out  32  instruction word, qualified by valid
icache_error_o  out  1  bus error on refill, qualified by valid
icache_page_fault_o  out  1  constant 0
mem_rd_o  out  1  memory word read request, held until accepted
mem_addr_o  out  32  word address, bits [1:0]=0
mem_accept_i  in  1  memory accepted read
mem_valid_i  in  1  read data return strobe
mem_data_i  in  32  read data
mem_error_i  in  1  bus error, qualified by mem_valid_i

Behaviour:
- Address split: offset = pc[3:2]; index = pc[4+IDX_W-1:4]; tag = pc[31:4+IDX_W].
- Storage:
  - valid bit per line, in flops with async reset to 0.
  - tag and data arrays are plain registers with no reset.
- FSM states: IDLE, LOOKUP, REFILL, FLUSH. Reset: state=IDLE, all outputs 0, flush_pending=0, valid bits all 0.
- icache_accept_o = !flush_pending & (state==IDLE | (state==LOOKUP & hit)). An accepted request latches pc into req_pc_q and goes to LOOKUP.
- No backpressure on responses: icache_valid_o is a 1-cycle pulse; the consumer must capture it.
- LOOKUP: hit = valid[idx] & tag match.
  - Hit: icache_valid_o=1, icache_inst_o=data[idx][offset], error=0.
  - Hit with a new request accepted in the same cycle: stay in LOOKUP with the new pc. Gives back-to-back hits at 1 per cycle.
  - Hit with no new request: go to IDLE.
  - Miss: go to REFILL with word counter=0 and error_acc=0.
- REFILL: issues LINE_WORDS sequential reads at {tag,index,cnt,2'b00}, cnt = 0..3, one outstanding at a time.
  - mem_rd_o asserted until mem_accept_i; it is not reasserted until the matching mem_valid_i.
  - Each mem_valid_i writes data[idx][cnt], ORs mem_error_i into error_acc, then increments cnt.
  - After beat 3 with error_acc=0: set valid[idx], write tag, return to LOOKUP. The re-lookup hits, so miss-to-valid latency = 1 (lookup) + 4 beats + 1 cycle.
  - After beat 3 with error_acc=1: do not set valid. Pulse icache_valid_o=1 with icache_error_o=1 and inst=0 in the following cycle, then go to IDLE.
- Flush/invalidate:
  - Either pulse sets flush_pending in any state, including same cycle as a request; accept_o is then low for that cycle.
  - In-progress LOOKUP/REFILL completes and delivers its response first.
  - The IDLE->FLUSH transition occurs when flush_pending=1 and state is IDLE, or at the point LOOKUP would go to IDLE.
  - FLUSH clears valid[i] for i = 0..NUM_LINES-1, one per cycle, counter wraps at NUM_LINES-1. Then flush_pending=0, state IDLE.
  - A flush pulse during FLUSH restarts the sweep at 0.
- Reset mid-refill abandons the transaction immediately. The memory side must itself reset with rst_i; no stale mem_valid_i is expected.
- icache_priv_i is ignored; icache_page_fault_o is tied to 0.

Decomposition:
- Package riscv_icache_defs: state encodings (ICACHE_IDLE, ICACHE_LOOKUP, ICACHE_REFILL, ICACHE_FLUSH), LINE_WORDS, and the offset/index/tag field-position macros.
- One natural sub-module: riscv_icache_lite_ram, holding the tag+data register array with a 1-read/1-write port and per-word write enable. Valid bits stay in the top level for async reset and the flush sweep.

Test Plan:
- Reset -> accept_o=1, valid_o=0, mem_rd_o=0; all valid bits 0 (probe).
- Cold miss at 0x100, memory returns 0x11,0x22,0x33,0x44 with 2-cycle latency -> mem reads at 0x100,0x104,0x108,0x10C in order. Then valid_o pulse with inst=0x11, error=0, exactly 1 cycle after the 4th mem_valid_i.
- Warm hits 0x104 then 0x108 issued back-to-back -> valid_o on consecutive cycles with 0x22,0x33; mem_rd_o stays 0.
- Refill of 0x200 where beat 2 has mem_error_i=1 -> a single response with error=1, inst=0. Re-request of 0x200 misses again and refills.
- Flush pulse during refill of 0x300 -> refill response delivered first. Then accept_o=0 for NUM_LINES cycles, after which re-request of 0x100 misses.
- Alias: fill 0x100, then request 0x100+NUM_LINES*16 -> miss and replacement. Subsequent 0x100 misses.

Source files
------------

// File: rtl/riscv_icache_lite_pkg.sv
// riscv_icache_defs: shared definitions for the riscv_icache_lite slice.
// Contents: FSM state encoding, line geometry and fetch-address field positions
// (offset = pc[3:2], index starts at bit 4, tag sits above the index).
package riscv_icache_defs;

    typedef enum logic [1:0] {
        ICACHE_IDLE   = 2'd0,
        ICACHE_LOOKUP = 2'd1,
        ICACHE_REFILL = 2'd2,
        ICACHE_FLUSH  = 2'd3
    } icache_state_t;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_LSB = 2;
    localparam int OFFSET_W   = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;

    // Tag width left over once offset and index bits are removed.
    function automatic int tag_width(input int idx_w);
        return 32 - INDEX_LSB - idx_w;
    endfunction

endpackage

// File: rtl/riscv_icache_lite_if.sv
// riscv_icache_lite_if: fetch-stage <-> instruction cache handshake.
// master (fetch): drives icache_rd/pc/priv/flush/invalidate.
// slave  (cache): drives icache_accept/valid/inst/error/page_fault.
interface riscv_icache_lite_if;
    logic        icache_rd;
    logic [31:0] icache_pc;
    logic [1:0]  icache_priv;
    logic        icache_flush;
    logic        icache_invalidate;
    logic        icache_accept;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        icache_error;
    logic        icache_page_fault;

    modport master (
        output icache_rd, icache_pc, icache_priv, icache_flush, icache_invalidate,
        input  icache_accept, icache_valid, icache_inst, icache_error, icache_page_fault
    );

    modport slave (
        input  icache_rd, icache_pc, icache_priv, icache_flush, icache_invalidate,
        output icache_accept, icache_valid, icache_inst, icache_error, icache_page_fault
    );
endinterface

// File: rtl/riscv_icache_lite_ram.sv
// riscv_icache_lite_ram: tag + data storage for the direct-mapped cache.
// Ports: clk_i; read port (rd_idx_i, rd_off_i -> rd_tag_o, rd_data_o, combinational);
// write port (wr_idx_i, wr_off_i, wr_data_en_i/wr_data_i per word, wr_tag_en_i/wr_tag_i).
// Contents are deliberately not reset; line validity lives in the parent.
module riscv_icache_lite_ram
    import riscv_icache_defs::*;
#(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 32 - INDEX_LSB - IDX_W
) (
    input  logic                clk_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    input  logic [OFFSET_W-1:0] rd_off_i,
    output logic [TAG_W-1:0]    rd_tag_o,
    output logic [31:0]         rd_data_o,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [OFFSET_W-1:0] wr_off_i,
    input  logic                wr_data_en_i,
    input  logic [31:0]         wr_data_i,
    input  logic                wr_tag_en_i,
    input  logic [TAG_W-1:0]    wr_tag_i
);
    logic [TAG_W-1:0] tag_r  [NUM_LINES];
    logic [31:0]      data_r [NUM_LINES*LINE_WORDS];

    assign rd_tag_o  = tag_r[rd_idx_i];
    assign rd_data_o = data_r[{rd_idx_i, rd_off_i}];

    // Storage write port: one data word per refill beat, tag once the line is good.
    always_ff @(posedge clk_i) begin
        if (wr_data_en_i) begin
            data_r[{wr_idx_i, wr_off_i}] <= wr_data_i;
        end
        if (wr_tag_en_i) begin
            tag_r[wr_idx_i] <= wr_tag_i;
        end
    end
endmodule

// File: rtl/riscv_icache_lite.sv
// riscv_icache_lite: blocking direct-mapped instruction cache.
// Ports: clk_i, rst_i (async, active-high); bus (fetch handshake, slave side);
// mem_rd_o/mem_addr_o/mem_accept_i (single-outstanding word read request),
// mem_valid_i/mem_data_i/mem_error_i (read return).
// Hits answer the cycle after acceptance; misses fetch a 4-word line, then re-look up.
module riscv_icache_lite
    import riscv_icache_defs::*;
#(
    parameter int NUM_LINES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    riscv_icache_lite_if.slave        bus,
    output logic                      mem_rd_o,
    output logic [31:0]               mem_addr_o,
    input  logic                      mem_accept_i,
    input  logic                      mem_valid_i,
    input  logic [31:0]               mem_data_i,
    input  logic                      mem_error_i
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = tag_width(IDX_W);

    icache_state_t        state_r, state_nxt_s;
    logic [31:2]          req_pc_r;
    logic [NUM_LINES-1:0] line_valid_r;
    logic                 flush_pending_r;
    logic [IDX_W-1:0]     flush_cnt_r;
    logic [1:0]           beat_cnt_r;
    logic                 err_acc_r, mem_rd_r, mem_wait_r, err_rsp_r;

    logic [IDX_W-1:0]     req_idx_s;
    logic [TAG_W-1:0]     req_tag_s, ram_tag_s;
    logic [31:0]          ram_data_s, rsp_inst_s;
    logic                 hit_s, accept_s, rsp_valid_s, rsp_err_s, take_s;
    logic                 flush_pulse_s, flush_req_s, flush_last_s;
    logic                 beat_s, last_beat_s, beat_err_s, start_refill_s, line_ok_s;
    logic                 unused_fetch_bits_s;

    assign req_idx_s      = req_pc_r[INDEX_LSB +: IDX_W];
    assign req_tag_s      = req_pc_r[31 -: TAG_W];
    assign hit_s          = line_valid_r[req_idx_s] & (ram_tag_s == req_tag_s);
    assign flush_pulse_s  = bus.icache_flush | bus.icache_invalidate;
    assign flush_req_s    = flush_pending_r | flush_pulse_s;
    assign flush_last_s   = (flush_cnt_r == IDX_W'(NUM_LINES - 1));
    assign beat_s         = mem_wait_r & mem_valid_i;
    assign last_beat_s    = beat_s & (beat_cnt_r == 2'd3);
    assign beat_err_s     = err_acc_r | mem_error_i;
    assign line_ok_s      = last_beat_s & ~beat_err_s;
    assign start_refill_s = (state_r == ICACHE_LOOKUP) & ~hit_s;
    assign take_s         = bus.icache_rd & accept_s;
    // No MMU: privilege and byte-offset bits carry no meaning here.
    assign unused_fetch_bits_s = &{1'b0, bus.icache_priv, bus.icache_pc[1:0]};

    riscv_icache_lite_ram #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_ram (
        .clk_i        (clk_i),
        .rd_idx_i     (req_idx_s),
        .rd_off_i     (req_pc_r[3:2]),
        .rd_tag_o     (ram_tag_s),
        .rd_data_o    (ram_data_s),
        .wr_idx_i     (req_idx_s),
        .wr_off_i     (beat_cnt_r),
        .wr_data_en_i (beat_s),
        .wr_data_i    (mem_data_i),
        .wr_tag_en_i  (line_ok_s),
        .wr_tag_i     (req_tag_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ICACHE_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, request acceptance and response strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_inst_s  = 32'h0;
        case (state_r)
            ICACHE_IDLE: begin
                accept_s = ~flush_req_s;
                if (flush_pending_r) begin
                    state_nxt_s = ICACHE_FLUSH;
                end else if (bus.icache_rd & ~flush_req_s) begin
                    state_nxt_s = ICACHE_LOOKUP;
                end else begin
                    state_nxt_s = ICACHE_IDLE;
                end
            end
            ICACHE_LOOKUP: begin
                if (hit_s) begin
                    rsp_valid_s = 1'b1;
                    rsp_inst_s  = ram_data_s;
                    accept_s    = ~flush_req_s;
                    // A request taken alongside a hit keeps streaming at one per cycle.
                    if (bus.icache_rd & ~flush_req_s) begin
                        state_nxt_s = ICACHE_LOOKUP;
                    end else if (flush_req_s) begin
                        state_nxt_s = ICACHE_FLUSH;
                    end else begin
                        state_nxt_s = ICACHE_IDLE;
                    end
                end else begin
                    state_nxt_s = ICACHE_REFILL;
                end
            end
            ICACHE_REFILL: begin
                if (err_rsp_r) begin
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    state_nxt_s = flush_req_s ? ICACHE_FLUSH : ICACHE_IDLE;
                end else if (line_ok_s) begin
                    state_nxt_s = ICACHE_LOOKUP;
                end else begin
                    state_nxt_s = ICACHE_REFILL;
                end
            end
            ICACHE_FLUSH: begin
                if (flush_last_s & ~flush_pulse_s) begin
                    state_nxt_s = ICACHE_IDLE;
                end else begin
                    state_nxt_s = ICACHE_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ICACHE_IDLE;
            end
        endcase
    end

    // Request capture, flush bookkeeping and refill sequencing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_pc_r        <= 30'h0;
            flush_pending_r <= 1'b0;
            flush_cnt_r     <= '0;
            beat_cnt_r      <= 2'd0;
            err_acc_r       <= 1'b0;
            mem_rd_r        <= 1'b0;
            mem_wait_r      <= 1'b0;
            err_rsp_r       <= 1'b0;
        end else begin
            if (take_s) begin
                req_pc_r <= bus.icache_pc[31:2];
            end
            if (flush_pulse_s) begin
                flush_pending_r <= 1'b1;
            end else if ((state_r == ICACHE_FLUSH) & flush_last_s) begin
                flush_pending_r <= 1'b0;
            end
            // A fresh pulse mid-sweep restarts the sweep from line 0.
            if ((state_r == ICACHE_FLUSH) & ~flush_pulse_s & ~flush_last_s) begin
                flush_cnt_r <= flush_cnt_r + IDX_W'(1);
            end else begin
                flush_cnt_r <= '0;
            end
            err_rsp_r <= (state_r == ICACHE_REFILL) & last_beat_s & beat_err_s;
            if (start_refill_s) begin
                beat_cnt_r <= 2'd0;
                err_acc_r  <= 1'b0;
                mem_rd_r   <= 1'b1;
                mem_wait_r <= 1'b0;
            end else begin
                if (mem_rd_r & mem_accept_i) begin
                    mem_rd_r   <= 1'b0;
                    mem_wait_r <= 1'b1;
                end
                if (beat_s) begin
                    beat_cnt_r <= beat_cnt_r + 2'd1;
                    err_acc_r  <= beat_err_s;
                    mem_wait_r <= 1'b0;
                    mem_rd_r   <= (beat_cnt_r != 2'd3);
                end
            end
        end
    end

    // Line valid bits: sweep clear, drop on miss (line is being overwritten), set on clean fill.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_valid_r <= '0;
        end else if (state_r == ICACHE_FLUSH) begin
            line_valid_r[flush_cnt_r] <= 1'b0;
        end else if (start_refill_s) begin
            line_valid_r[req_idx_s] <= 1'b0;
        end else if ((state_r == ICACHE_REFILL) & line_ok_s) begin
            line_valid_r[req_idx_s] <= 1'b1;
        end
    end

    assign bus.icache_accept     = accept_s;
    assign bus.icache_valid      = rsp_valid_s;
    assign bus.icache_inst       = rsp_inst_s;
    assign bus.icache_error      = rsp_err_s;
    assign bus.icache_page_fault = 1'b0;
    assign mem_rd_o              = mem_rd_r;
    assign mem_addr_o            = {req_pc_r[31:4], beat_cnt_r, 2'b00};
endmodule

// File: tb/tb_riscv_icache_lite.sv
// tb_riscv_icache_lite: directed scenarios followed by random traffic, checked each
// cycle against a line-level cache model and a backing-memory function.
module tb_riscv_icache_lite;
    import riscv_icache_defs::*;

    localparam int N     = 64;
    localparam int IDX_W = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_icache_lite_if bus();
    logic        mem_rd, mem_accept, mem_valid, mem_error;
    logic [31:0] mem_addr, mem_data;

    riscv_icache_lite #(.NUM_LINES(N)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_accept_i(mem_accept),
        .mem_valid_i(mem_valid), .mem_data_i(mem_data), .mem_error_i(mem_error)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; int cyc; } rsp_t;

    int errors = 0, checks = 0, cyc = 0;
    // model of cache contents
    bit          line_v   [N];
    logic [31:0] line_tag [N];
    bit busy = 0, rsp_due = 0, rsp_err = 0, miss_act = 0, eacc = 0, flush_pend = 0;
    logic [31:0] rsp_inst, req_pc;
    logic [31:0] rd_q[$];
    int beats = 0, ready_cyc = 0, last_beat_cyc = 0;
    // memory responder
    bit md_pend = 0; int md_delay = 0; logic [31:0] md_addr;
    logic [31:0] override [logic [31:0]];
    bit          force_err [logic [31:0]];
    // stimulus
    logic [31:0] req_q[$];
    bit rand_mode = 0, do_flush = 0;
    rsp_t rlog[$];
    logic [31:0] alog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (override.exists(a)) return override[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic step();
        bit resp_now, resp_was_err, fl_now, exp_acc;
        int idx;
        logic [31:0] wa, pcv;
        @(negedge clk);
        // memory side drive
        mem_valid = 1'b0; mem_error = 1'b0; mem_data = 32'h0;
        if (md_pend) begin
            md_delay--;
            if (md_delay == 0) begin
                mem_valid = 1'b1;
                mem_data  = memfn(md_addr);
                if (force_err.exists(md_addr)) begin
                    mem_error = 1'b1;
                    force_err.delete(md_addr);
                end else if (rand_mode && $urandom_range(0, 15) == 0) begin
                    mem_error = 1'b1;
                end
                md_pend = 0;
            end
        end
        mem_accept = mem_rd && !md_pend && (!rand_mode || $urandom_range(0, 1) == 1);
        // fetch side drive
        pcv = (32'($urandom_range(0, 2)) << (4 + IDX_W)) | (32'($urandom_range(0, 3)) << 4)
            | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        bus.icache_rd   = (req_q.size() != 0) || (rand_mode && $urandom_range(0, 2) != 0);
        bus.icache_pc   = (req_q.size() != 0) ? req_q[0] : pcv;
        bus.icache_priv = 2'($urandom_range(0, 3));
        bus.icache_flush      = do_flush || (rand_mode && $urandom_range(0, 79) == 0);
        bus.icache_invalidate = rand_mode && $urandom_range(0, 149) == 0;
        do_flush = 0;
        #1;
        cyc++;
        // response check
        resp_now = 0; resp_was_err = 0;
        if (rsp_due) begin
            chk("rsp_valid", bus.icache_valid, 1);
            chk("rsp_inst", bus.icache_inst, rsp_inst);
            chk("rsp_err", bus.icache_error, rsp_err);
            rlog.push_back('{req_pc, bus.icache_inst, bus.icache_error, cyc});
            rsp_due = 0; busy = 0; resp_now = 1; resp_was_err = rsp_err;
            if (flush_pend) ready_cyc = cyc;
        end else begin
            chk("spurious_valid", bus.icache_valid, 0);
        end
        chk("page_fault", bus.icache_page_fault, 0);
        // flush tracking: accept must stay low for the whole sweep
        fl_now = bus.icache_flush || bus.icache_invalidate;
        if (fl_now) begin
            flush_pend = 1;
            if (!busy) ready_cyc = cyc;
        end
        if (flush_pend && !fl_now && !busy && bus.icache_accept) begin
            chk("flush_len_ok", (cyc - ready_cyc >= N + 1) && (cyc - ready_cyc <= N + 2), 1);
            flush_pend = 0;
            for (int i = 0; i < N; i++) line_v[i] = 0;
        end else if (flush_pend && !busy && (cyc - ready_cyc > N + 2)) begin
            chk("flush_end", cyc - ready_cyc, N + 2);
            flush_pend = 0;
            for (int i = 0; i < N; i++) line_v[i] = 0;
        end
        exp_acc = !flush_pend && !fl_now && !busy;
        if (!(resp_now && resp_was_err)) chk("accept", bus.icache_accept, exp_acc);
        // request acceptance
        if (bus.icache_rd && bus.icache_accept) begin
            if (req_q.size() != 0) void'(req_q.pop_front());
            wa = bus.icache_pc & ~32'h3;
            idx = int'((wa >> 4) % N);
            busy = 1; req_pc = wa;
            if (line_v[idx] && line_tag[idx] == (wa >> (4 + IDX_W))) begin
                rsp_due = 1; rsp_inst = memfn(wa); rsp_err = 0;
            end else begin
                line_v[idx] = 0; miss_act = 1; beats = 0; eacc = 0;
                for (int k = 0; k < 4; k++) rd_q.push_back((wa & ~32'hF) + 32'(4 * k));
            end
        end
        // memory request side
        if (mem_accept && mem_rd) begin
            if (rd_q.size() == 0) chk("unexpected_read", mem_addr, 32'hFFFF_FFFF);
            else chk("read_addr", mem_addr, rd_q.pop_front());
            alog.push_back(mem_addr);
            md_pend = 1; md_delay = rand_mode ? $urandom_range(1, 3) : 2; md_addr = mem_addr;
        end
        if (!miss_act) chk("mem_rd_idle", mem_rd, 0);
        if (mem_valid) begin
            beats++; eacc |= mem_error;
            if (beats == 4) begin
                miss_act = 0; last_beat_cyc = cyc; rsp_due = 1;
                idx = int'((req_pc >> 4) % N);
                if (!eacc) begin
                    line_v[idx] = 1; line_tag[idx] = req_pc >> (4 + IDX_W);
                    rsp_inst = memfn(req_pc); rsp_err = 0;
                end else begin
                    rsp_inst = 32'h0; rsp_err = 1;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((req_q.size() != 0 || busy || flush_pend || miss_act) && n < 2000) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, n < 2000, 1);
    endtask

    initial begin
        rsp_t r, r1;
        int n;
        for (int i = 0; i < N; i++) begin line_v[i] = 0; line_tag[i] = 32'h0; end
        override[32'h100] = 32'h11; override[32'h104] = 32'h22;
        override[32'h108] = 32'h33; override[32'h10C] = 32'h44;
        rst = 1'b1;
        bus.icache_rd = 1'b0; bus.icache_pc = 32'h0; bus.icache_priv = 2'd0;
        bus.icache_flush = 1'b0; bus.icache_invalidate = 1'b0;
        mem_accept = 1'b0; mem_valid = 1'b0; mem_error = 1'b0; mem_data = 32'h0;
        repeat (3) step();
        chk("reset_valid_bits", dut.line_valid_r, 64'h0);
        rst = 1'b0;
        step();

        // cold miss
        req_q.push_back(32'h100);
        wait_idle("cold");
        r = rlog[rlog.size() - 1];
        chk("cold_inst", r.inst, 32'h11);
        chk("cold_err", r.err, 0);
        chk("cold_latency", r.cyc, last_beat_cyc + 1);
        chk("cold_reads", alog.size(), 4);
        for (int k = 0; k < 4; k++) chk("cold_addr", alog[k], 32'h100 + 32'(4 * k));

        // warm back-to-back hits
        req_q.push_back(32'h104); req_q.push_back(32'h108);
        wait_idle("warm");
        r1 = rlog[rlog.size() - 2]; r = rlog[rlog.size() - 1];
        chk("warm_inst0", r1.inst, 32'h22);
        chk("warm_inst1", r.inst, 32'h33);
        chk("warm_b2b", r.cyc - r1.cyc, 1);
        chk("warm_no_reads", alog.size(), 4);

        // refill with bus error on beat 2, then retry
        force_err[32'h208] = 1;
        req_q.push_back(32'h200);
        wait_idle("err");
        r = rlog[rlog.size() - 1];
        chk("err_flag", r.err, 1);
        chk("err_inst", r.inst, 32'h0);
        chk("err_reads", alog.size(), 8);
        req_q.push_back(32'h200);
        wait_idle("retry");
        r = rlog[rlog.size() - 1];
        chk("retry_err", r.err, 0);
        chk("retry_reads", alog.size(), 12);

        // flush during refill
        req_q.push_back(32'h300);
        n = 0;
        while (!(miss_act && beats >= 1) && n < 200) begin step(); n++; end
        chk("flush_setup_timeout", n < 200, 1);
        do_flush = 1;
        wait_idle("flush");
        r = rlog[rlog.size() - 1];
        chk("flush_rsp_pc", r.pc, 32'h300);
        chk("flush_rsp_err", r.err, 0);
        req_q.push_back(32'h100);
        wait_idle("post_flush");
        chk("post_flush_miss", alog.size(), 20);

        // alias replacement
        req_q.push_back(32'h100 + 32'(N * 16));
        wait_idle("alias");
        chk("alias_miss", alog.size(), 24);
        req_q.push_back(32'h100);
        wait_idle("alias_back");
        chk("alias_back_miss", alog.size(), 28);
        chk("alias_back_inst", rlog[rlog.size() - 1].inst, 32'h11);

        // random traffic
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) step();
        rand_mode = 0;
        wait_idle("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
